// File: rtl/execution_skid_buffer.sv
// Two-entry skid buffer between execute and memory stages: a head register
// drives the outputs, a skid register absorbs one extra entry so in_ready can be registered.
module execution_skid_buffer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_operand_b,
  input  logic [ADDR_W-1:0] in_write_addr,
  input  logic [4:0]        in_ctrl,
  input  logic [FLAG_W-1:0] in_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_operand_b,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic [4:0]        out_ctrl,
  output logic [FLAG_W-1:0] out_flags,
  output logic [1:0]        occupancy
);

  localparam int ENT_W = 2 * DATA_W + ADDR_W + 5 + FLAG_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_in_ready;
  logic [ENT_W-1:0]   r_head;
  logic [ENT_W-1:0]   r_skid;

  logic [ENT_W-1:0]   w_in_entry;
  logic [4:0]         w_head_ctrl;
  logic               w_accept;
  logic               w_pop;

  assign w_in_entry = {in_alu_result, in_operand_b, in_write_addr, in_ctrl, in_flags};
  assign {out_alu_result, out_operand_b, out_write_addr, w_head_ctrl, out_flags} = r_head;

  assign out_valid = (r_state != S_EMPTY);
  // An empty slot must never carry write/flag enables downstream.
  assign out_ctrl  = out_valid ? w_head_ctrl : 5'd0;
  assign in_ready  = r_in_ready;
  assign occupancy = r_state;

  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_head     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      // Data registers are left as-is; only the state is dropped.
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_head  <= w_in_entry;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            r_head <= w_in_entry;
          end else if (w_accept) begin
            r_skid     <= w_in_entry;
            r_state    <= S_FULL;
            r_in_ready <= 1'b0;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_head     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/execution_skid_buffer.md
EXECUTION_SKID_BUFFER -- requirements
Module: execution_skid_buffer

Interface
REQ-001 Parameter DATA_W, default 64: width of ALU result and operand B.
REQ-002 Parameter ADDR_W, default 5: width of register write address.
REQ-003 Parameter FLAG_W, default 4: width of condition flags.
REQ-004 Port clk  input  1  single clock, all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port flush  input  1  discard all held and incoming entries.
REQ-007 Port in_valid  input  1  upstream (execute) entry present.
REQ-008 Port in_ready  output  1  buffer can accept an entry this cycle.
REQ-009 Port in_alu_result, in_operand_b  input  DATA_W each  execute data.
REQ-010 Port in_write_addr  input  ADDR_W  destination register.
REQ-011 Port in_ctrl  input  5  {regwrite, memwrite, memtoreg, branch, setflags}.
REQ-012 Port in_flags  input  FLAG_W  flag values.
REQ-013 Port out_valid  output  1  head entry presented to memory stage.
REQ-014 Port out_ready  input  1  memory stage consumes head this cycle.
REQ-015 Ports out_alu_result, out_operand_b, out_write_addr, out_ctrl, out_flags  output  widths matching REQ-009..012  head entry fields.
REQ-016 Port occupancy  output  2  held entries, 0..2.

Function
REQ-017 Storage SHALL be two entries: head register (drives outputs) and skid register; states EMPTY (0), ONE (1), FULL (2), occupancy equal to state.
REQ-018 Accept SHALL occur when in_valid && in_ready at a rising edge; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be a registered signal, equal to (state != FULL); no combinational path from out_ready to in_ready.
REQ-020 out_valid SHALL equal (state != EMPTY).
REQ-021 Latency SHALL be one cycle: entry accepted at edge N is on outputs with out_valid=1 after edge N when buffer was EMPTY.
REQ-022 Order SHALL be FIFO; no entry duplicated or dropped except by flush/rst.
REQ-023 EMPTY: accept -> load head, ONE; else stay EMPTY.
REQ-024 ONE: accept without pop -> load skid, FULL; pop without accept -> EMPTY; accept and pop together -> head loaded with new entry, stay ONE.
REQ-025 FULL: pop -> skid moves to head, ONE; no pop -> hold, FULL; no accept possible (in_ready=0).
REQ-026 Head and skid data SHALL hold unchanged while not written; out_* SHALL be stable whenever out_valid=1 and out_ready=0.
REQ-027 out_ctrl SHALL be forced to 0 whenever out_valid=0, so no register/memory write or flag set reaches downstream from an invalid slot.
REQ-028 flush SHALL take priority over accept and pop: next state EMPTY, in_ready=1, any entry offered that cycle discarded; pop in the flush cycle still counts as consumed.
REQ-029 flush SHALL NOT alter data registers other than via REQ-027 gating.
REQ-030 All field widths SHALL track parameters with no truncation or extension.

Reset
REQ-031 rst SHALL override flush, accept and pop.
REQ-032 After rst: state EMPTY, occupancy 0, out_valid 0, in_ready 1, head and skid data all zeros, out_ctrl 0.
REQ-033 rst asserted mid-operation in FULL SHALL discard both entries in one cycle.

Verification
REQ-034 Reset then in_valid=1, alu_result=0x11, out_ready=1 -> next cycle out_valid=1, out_alu_result=0x11, occupancy=1.
REQ-035 out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0, out_alu_result=0xA held; raise out_ready -> 0xA then 0xB on consecutive cycles, then out_valid=0.
REQ-036 ONE state with head 0x1, simultaneous push 0x2 and pop -> occupancy stays 1, out_alu_result=0x2.
REQ-037 FULL with in_ctrl regwrite=1 entries, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; offered entry never appears.
REQ-038 Random in_valid/out_ready for 10000 cycles, DATA_W=32 ADDR_W=6 build -> output sequence equals input sequence, out_* stable under backpressure, in_ready never depends on same-cycle out_ready.
